// File: rtl/poly_mem_xbar.sv
// ----------------------------------------------------------------------------
// poly_mem_xbar
//   Crossbar between NUM_CLIENTS polynomial-engine clients and NUM_BANKS
//   dual-port coefficient RAM banks. Each bank serves up to two clients per
//   cycle (port A, then port B) in round-robin order starting at the bank's
//   own pointer. A request is not granted if an earlier grant on the same
//   bank and address this cycle is a write.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   cl_req_i         per-client request
//   cl_we_i          per-client write enable (1 = write, 0 = read)
//   cl_bank_i        per-client target bank, flattened [c*BANK_W +: BANK_W]
//   cl_addr_i        per-client word address, flattened [c*ADDR_W +: ADDR_W]
//   cl_wdata_i       per-client write data, flattened [c*W +: W]
//   cl_gnt_o         per-client grant, combinational
//   cl_rvalid_o      per-client read data valid, one cycle after read grant
//   cl_rdata_o       per-client read data, flattened, 0 when not valid
//   stall_cnt_clr_i  clears the stall counter
//   stall_cnt_o      saturating count of cycles with an ungranted request
// ----------------------------------------------------------------------------

// Dual-port coefficient RAM with 1-cycle registered read on both ports.
// Read returns the old contents when the other port writes the same word.
module poly_ram_bank #(
    parameter int N      = 256,
    parameter int W      = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [W-1:0]      a_wdata_i,
    output logic [W-1:0]      a_rdata_o,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [W-1:0]      b_wdata_i,
    output logic [W-1:0]      b_rdata_o
);
    logic [W-1:0] mem_q [N];
    logic [W-1:0] a_rdata_q;
    logic [W-1:0] b_rdata_q;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    // Registered read data for both ports.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= mem_q[a_addr_i];
            b_rdata_q <= mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;
endmodule

module poly_mem_xbar #(
    parameter int NUM_BANKS   = 4,
    parameter int N           = 256,
    parameter int W           = 16,
    parameter int ADDR_W      = $clog2(N),
    parameter int NUM_CLIENTS = 4,
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CL_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CLIENTS-1:0]        cl_req_i,
    input  logic [NUM_CLIENTS-1:0]        cl_we_i,
    input  logic [NUM_CLIENTS*BANK_W-1:0] cl_bank_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr_i,
    input  logic [NUM_CLIENTS*W-1:0]      cl_wdata_i,
    output logic [NUM_CLIENTS-1:0]        cl_gnt_o,
    output logic [NUM_CLIENTS-1:0]        cl_rvalid_o,
    output logic [NUM_CLIENTS*W-1:0]      cl_rdata_o,
    input  logic                          stall_cnt_clr_i,
    output logic [31:0]                   stall_cnt_o
);
    // Per-bank port signals
    logic              bk_a_we_s    [NUM_BANKS];
    logic [ADDR_W-1:0] bk_a_addr_s  [NUM_BANKS];
    logic [W-1:0]      bk_a_wdata_s [NUM_BANKS];
    logic [W-1:0]      bk_a_rdata_s [NUM_BANKS];
    logic              bk_b_we_s    [NUM_BANKS];
    logic [ADDR_W-1:0] bk_b_addr_s  [NUM_BANKS];
    logic [W-1:0]      bk_b_wdata_s [NUM_BANKS];
    logic [W-1:0]      bk_b_rdata_s [NUM_BANKS];

    // Arbitration state
    logic [CL_W-1:0]   rr_ptr_q     [NUM_BANKS];
    logic [CL_W-1:0]   rr_ptr_d     [NUM_BANKS];

    // Per-client read tags: which bank/port answers next cycle
    logic [NUM_CLIENTS-1:0] tag_valid_q;
    logic [NUM_CLIENTS-1:0] tag_valid_d;
    logic [BANK_W-1:0]      tag_bank_q [NUM_CLIENTS];
    logic [BANK_W-1:0]      tag_bank_d [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] tag_port_q;
    logic [NUM_CLIENTS-1:0] tag_port_d;

    logic [NUM_CLIENTS-1:0] gnt_s;
    logic                   stall_s;
    logic [31:0]            stall_cnt_q;
    logic [31:0]            stall_cnt_d;

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        poly_ram_bank #(
            .N      (N),
            .W      (W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_i     (clk_i),
            .rst_n_i   (!rst_i),
            .a_we_i    (bk_a_we_s[gb]),
            .a_addr_i  (bk_a_addr_s[gb]),
            .a_wdata_i (bk_a_wdata_s[gb]),
            .a_rdata_o (bk_a_rdata_s[gb]),
            .b_we_i    (bk_b_we_s[gb]),
            .b_addr_i  (bk_b_addr_s[gb]),
            .b_wdata_i (bk_b_wdata_s[gb]),
            .b_rdata_o (bk_b_rdata_s[gb])
        );
    end

    // Per-bank round-robin arbitration, port steering and read-tag capture.
    always_comb begin
        logic [1:0]        n_gnt;
        logic              a_we;
        logic [ADDR_W-1:0] a_addr;
        logic              elig;
        logic [ADDR_W-1:0] c_addr;
        int                c;

        gnt_s       = '0;
        tag_valid_d = '0;
        tag_port_d  = tag_port_q;
        n_gnt       = 2'd0;
        a_we        = 1'b0;
        a_addr      = '0;
        elig        = 1'b0;
        c_addr      = '0;
        c           = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            tag_bank_d[i] = tag_bank_q[i];
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            bk_a_we_s[b]    = 1'b0;
            bk_a_addr_s[b]  = '0;
            bk_a_wdata_s[b] = '0;
            bk_b_we_s[b]    = 1'b0;
            bk_b_addr_s[b]  = '0;
            bk_b_wdata_s[b] = '0;
            rr_ptr_d[b]     = rr_ptr_q[b];
        end

        if (!rst_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                n_gnt  = 2'd0;
                a_we   = 1'b0;
                a_addr = '0;
                for (int k = 0; k < NUM_CLIENTS; k++) begin
                    c      = (int'(rr_ptr_q[b]) + k) % NUM_CLIENTS;
                    c_addr = cl_addr_i[c*ADDR_W +: ADDR_W];
                    elig   = cl_req_i[c]
                           && (cl_bank_i[c*BANK_W +: BANK_W] == BANK_W'(b))
                           && (n_gnt < 2'd2);
                    // A write already granted on port A blocks any later
                    // access to the same word this cycle.
                    if (elig && (n_gnt == 2'd1) && a_we && (a_addr == c_addr)) begin
                        elig = 1'b0;
                    end else begin
                        elig = elig;
                    end
                    if (elig) begin
                        gnt_s[c]       = 1'b1;
                        tag_valid_d[c] = !cl_we_i[c];
                        tag_bank_d[c]  = BANK_W'(b);
                        tag_port_d[c]  = (n_gnt == 2'd1);
                        rr_ptr_d[b]    = CL_W'((c + 1) % NUM_CLIENTS);
                        if (n_gnt == 2'd0) begin
                            bk_a_we_s[b]    = cl_we_i[c];
                            bk_a_addr_s[b]  = c_addr;
                            bk_a_wdata_s[b] = cl_wdata_i[c*W +: W];
                            a_we            = cl_we_i[c];
                            a_addr          = c_addr;
                        end else begin
                            bk_b_we_s[b]    = cl_we_i[c];
                            bk_b_addr_s[b]  = c_addr;
                            bk_b_wdata_s[b] = cl_wdata_i[c*W +: W];
                        end
                        n_gnt = n_gnt + 2'd1;
                    end else begin
                        n_gnt = n_gnt;
                    end
                end
            end
        end else begin
            gnt_s = '0;
        end
    end

    assign cl_gnt_o = gnt_s;
    assign stall_s  = |(cl_req_i & ~gnt_s);

    // Stall counter next state: clear beats increment, increment saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr_i) begin
            stall_cnt_d = 32'd0;
        end else if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Arbitration pointers, read tags and stall counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= '0;
            end
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                tag_bank_q[i] <= '0;
            end
            tag_valid_q <= '0;
            tag_port_q  <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                rr_ptr_q[b] <= rr_ptr_d[b];
            end
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                tag_bank_q[i] <= tag_bank_d[i];
            end
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset in the cycle after a read grant cancels that read's response.
    assign cl_rvalid_o = tag_valid_q & {NUM_CLIENTS{!rst_i}};
    assign stall_cnt_o = stall_cnt_q;

    // Return path: each client's tag picks the bank port that served it.
    always_comb begin
        cl_rdata_o = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!cl_rvalid_o[i]) begin
                cl_rdata_o[i*W +: W] = '0;
            end else if (tag_port_q[i]) begin
                cl_rdata_o[i*W +: W] = bk_b_rdata_s[tag_bank_q[i]];
            end else begin
                cl_rdata_o[i*W +: W] = bk_a_rdata_s[tag_bank_q[i]];
            end
        end
    end
endmodule
